// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding select and load-use stall generation
// for a classic 5-stage pipeline.
//
// The block tracks the destination of the instructions in EX, MEM and WB
// with three shadow entries {wr_en, is_load, rd}. From these entries it
// produces:
//   - registered EX operand-mux selects o_fwd_a / o_fwd_b
//     (00 = register file, 01 = EX/MEM result, 10 = MEM/WB result)
//   - a combinational o_stall that holds PC and the ID register
//
// Build option FWD_HAZARD_MEMWB_PATH_EN:
//   defined   : the MEM/WB forwarding path exists, so a MEM-stage producer is
//               forwarded with select 10, and a load-use hazard costs one
//               stall cycle.
//   undefined : no MEM/WB path. A MEM-stage producer stalls the consumer for
//               one cycle until the producer reaches WB, where the write-first
//               register file supplies the value (select 00). A load-use
//               hazard therefore costs two stall cycles. Select 10 is never
//               produced.
//
// Register 0 never matches. The ID instruction is compared only against
// older entries, so an instruction that reads and writes the same register
// never hazards on itself.

module fwd_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
    input  logic                      i_id_wr_en,
    input  logic                      i_id_is_load,
    input  logic                      i_flush,
    output logic [1:0]                o_fwd_a,
    output logic [1:0]                o_fwd_b,
    output logic                      o_stall
);

    typedef struct packed {
        logic                      wr_en;
        logic                      is_load;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } entry_t;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
`ifdef FWD_HAZARD_MEMWB_PATH_EN
    localparam logic [1:0] SEL_MEMWB = 2'b10;
`endif

    localparam entry_t BUBBLE = '{wr_en: 1'b0, is_load: 1'b0, rd: '0};

    entry_t     ex_q, mem_q, wb_q;
    entry_t     ex_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    logic       ex_match_a, ex_match_b;
    logic       mem_match_a, mem_match_b;
    logic       stall_a, stall_b;
    logic       stall;

    // A shadow entry matches a source when it writes that (nonzero) register.
    function automatic logic src_match(input entry_t e,
                                       input logic [REG_ADDR_WIDTH-1:0] src);
        return e.wr_en && (e.rd == src) && (src != '0);
    endfunction

    // Hazard detection, stall, next forwarding selects and next EX entry.
    always_comb begin
        ex_match_a  = src_match(ex_q,  i_id_rs);
        ex_match_b  = src_match(ex_q,  i_id_rt);
        mem_match_a = src_match(mem_q, i_id_rs);
        mem_match_b = src_match(mem_q, i_id_rt);

`ifdef FWD_HAZARD_MEMWB_PATH_EN
        // Only a load in EX cannot be forwarded in time.
        stall_a = ex_match_a && ex_q.is_load;
        stall_b = ex_match_b && ex_q.is_load;
`else
        // The nearer EX producer shadows a MEM producer of the same register;
        // a MEM producer alone has no path and must wait for WB.
        stall_a = ex_match_a ? ex_q.is_load : mem_match_a;
        stall_b = ex_match_b ? ex_q.is_load : mem_match_b;
`endif

        // Flush wins over stall; during reset all entries are treated as invalid.
        stall = !i_rst && i_id_valid && !i_flush && (stall_a || stall_b);

        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        if (i_id_valid && !stall && !i_flush) begin
            if (ex_match_a) begin
                fwd_a_d = SEL_EXMEM;
            end
`ifdef FWD_HAZARD_MEMWB_PATH_EN
            else if (mem_match_a) begin
                fwd_a_d = SEL_MEMWB;
            end
`endif
            if (ex_match_b) begin
                fwd_b_d = SEL_EXMEM;
            end
`ifdef FWD_HAZARD_MEMWB_PATH_EN
            else if (mem_match_b) begin
                fwd_b_d = SEL_MEMWB;
            end
`endif
        end

        ex_d = BUBBLE;
        if (i_id_valid && !stall && !i_flush) begin
            ex_d.wr_en   = i_id_wr_en;
            // A load that writes nothing cannot create a load-use hazard.
            ex_d.is_load = i_id_is_load && i_id_wr_en;
            ex_d.rd      = i_id_rd;
        end
    end

    // Shadow pipeline advance and registered forwarding selects.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q    <= BUBBLE;
            mem_q   <= BUBBLE;
            wb_q    <= BUBBLE;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // Sanity check on state that only travels to retirement.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (wb_q.wr_en || !wb_q.is_load);
            assert (fwd_a_q != 2'b11 && fwd_b_q != 2'b11);
        end
    end

    assign o_fwd_a = fwd_a_q;
    assign o_fwd_b = fwd_b_q;
    assign o_stall = stall;

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Parameter: REG_ADDR_WIDTH, default 5, register-file address width.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset; synchronous and active-high.
REQ-004 i_id_valid  input  1  a real instruction is in ID this cycle.
REQ-005 i_id_rs, i_id_rt  input  REG_ADDR_WIDTH each  source registers of the ID instruction.
REQ-006 i_id_rd  input  REG_ADDR_WIDTH  destination register of the ID instruction.
REQ-007 i_id_wr_en  input  1  the ID instruction writes i_id_rd.
REQ-008 i_id_is_load  input  1  the ID instruction is a load.
REQ-009 i_flush  input  1  squash the ID instruction; a bubble enters EX.
REQ-010 o_fwd_a, o_fwd_b  output  2 each  operand A/B select for the 3-input EX operand muxes: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
REQ-011 o_stall  output  1  hold PC and the ID register this cycle.

Function
REQ-012 The block SHALL keep three shadow entries (EX, MEM, WB), each holding {wr_en, is_load, rd}.
REQ-013 Each cycle without reset: WB<=MEM and MEM<=EX. EX<=ID entry when i_id_valid and not o_stall and not i_flush; otherwise EX<=bubble (wr_en=0).
REQ-014 A match SHALL mean: shadow wr_en=1, shadow rd equals the source, and the source is nonzero. Register 0 never matches.
REQ-015 o_fwd_a/o_fwd_b SHALL be registered. They are computed from i_id_rs/i_id_rt on the cycle the instruction leaves ID, and are valid during its EX cycle.
REQ-016 Select encoding: match with the EX entry -> 01; otherwise match with the MEM entry -> 10; otherwise 00. The nearer stage wins when both match.
REQ-017 o_stall SHALL be combinational from the current shadow state and the ID inputs. It asserts when i_id_valid=1 and a source matches an EX entry with is_load=1 (load-use).
REQ-018 When o_stall=1 or i_flush=1, the registered o_fwd_a/o_fwd_b SHALL load 00 (the bubble uses register-file operands).
REQ-019 i_flush=1 SHALL suppress o_stall in the same cycle; flush has priority.
REQ-020 Select code 11 SHALL never be driven.
REQ-021 A load-use stall SHALL last exactly one cycle. On the next cycle the load sits in MEM and is forwarded per REQ-016 (code 10).
REQ-022 An ID instruction reading and writing the same register SHALL compare only against older entries, never against itself.

Reset
REQ-023 While i_rst=1 at a clock edge: all shadow wr_en and is_load <=0, all rd <=0, o_fwd_a=o_fwd_b<=00.
REQ-024 During reset o_stall SHALL evaluate to 0 because all shadow entries are invalid. This holds when reset arrives mid-stall.
REQ-025 The first ID instruction after reset deassertion SHALL see no hazards.

Configuration
REQ-026 Macro FWD_HAZARD_MEMWB_PATH_EN SHALL compile the MEM/WB forwarding path in or out.
REQ-027 With FWD_HAZARD_MEMWB_PATH_EN defined, the block SHALL behave as in REQ-016 and REQ-021.
REQ-028 Without FWD_HAZARD_MEMWB_PATH_EN:
- Code 10 SHALL never be produced.
- A match with the MEM entry SHALL assert o_stall for one cycle.
- A load-use hazard SHALL stall two consecutive cycles.
- After the stall the producer is in WB and the operand is read as 00 from the write-first register file.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- add r3 in ID, then sub reading rs=r3 the next cycle -> o_fwd_a=01 during sub's EX, o_stall=0 throughout.
- Producer writes r5, one independent instruction, then consumer reads rt=r5 -> o_fwd_b=10 with the macro. Without the macro: o_stall=1 for one cycle, then o_fwd_b=00.
- lw r7, immediately followed by use of r7 -> o_stall=1 for exactly 1 cycle (2 without the macro), bubble selects 00, then o_fwd=10 for the consumer (00 without the macro).
- Writer of r0 followed by a reader of r0 -> o_fwd=00, o_stall=0.
- Two writers of r4 back-to-back, then a reader of r4 -> 01 (the nearer one wins).
- lw r2 in EX with a dependent instruction in ID while i_flush=1 -> o_stall=0; i_rst asserted during a stall -> o_stall=0 and o_fwd=00 the next cycle.
